sha_msg_ctrl: RTL and testbench
===============================

// Module: sha_msg_ctrl
// PURPOSE
//  Message sequencer in front of the SHA compression core. It accepts a byte stream, packs
//  bytes into NL-byte blocks and applies FIPS-180 padding plus the big-endian bit length,
//  inserting an extra pad block when needed. It issues each block to the core over a
//  valid/ready handshake and waits for the core's done pulse before refilling the buffer.
// PARAMETERS
//  NL    64  block size in bytes (64 = SHA-224/256, 128 = SHA-384/512)
//  LENB  8   length-field size in bytes (8 for NL=64, 16 for NL=128)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  clr        in   1       synchronous abort; returns to IDLE, discards message
//  in_valid   in   1       byte available
//  in_ready   out  1       byte accepted when in_valid & in_ready
//  in_data    in   8       message byte
//  in_last    in   1       qualifies final byte of message (messages are >= 1 byte)
//  blk_valid  out  1       block on blk_data valid for core
//  blk_ready  in   1       core accepts block
//  blk_data   out  8*NL    block; byte k at [8*(NL-1-k) +: 8] (byte 0 = MSB)
//  blk_first  out  1       block is first of message (core loads IV)
//  blk_last   out  1       block is final of message
//  core_done  in   1       one-cycle pulse: core finished the issued block
//  msg_done   out  1       one-cycle pulse: final block compressed, digest ready in core
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE. All outputs 0, buffer 0, byte count cnt=0,
//    bitlen=0, first=1, pad_pend=0, len_pend=0. clr has the same effect on the next edge.
//    clr has priority over every other event.
//  - in_ready=1 only in IDLE and FILL. All other states stall input.
//  - IDLE: an accepted byte writes buf[0], sets cnt=1, bitlen=8, first=1, then goes to FILL.
//    If the accepted byte is the last byte, go to PAD.
//  - FILL: each accepted byte writes buf[cnt], cnt++, bitlen+=8.
//      * If the byte is last and cnt_new < NL: go to PAD.
//      * If cnt_new == NL: go to ISSUE with blk_last=0. If the byte is also last, set pad_pend=1.
//  - PAD (1 cycle): buf[cnt]=0x80, and bytes cnt+1..NL-1 are set to 0.
//      * If cnt+1 <= NL-LENB: the last LENB bytes get bitlen (big-endian), blk_last=1.
//      * Otherwise set len_pend=1 and blk_last=0.
//    Then go to ISSUE.
//  - ISSUE: blk_valid=1. blk_data, blk_first and blk_last are held stable until blk_ready.
//    On the handshake cycle: first<=0, go to WAIT.
//  - WAIT: blk_valid=0. On core_done:
//      * blk_last=1: go to DONE.
//      * pad_pend: buffer=0, buf[0]=0x80, length in tail, blk_last=1, pad_pend=0, go to ISSUE.
//      * len_pend: buffer=0, length in tail, blk_last=1, len_pend=0, go to ISSUE.
//      * Otherwise: cnt=0, go to FILL.
//    A core_done pulse outside WAIT is ignored.
//  - DONE: msg_done=1 for exactly 1 cycle. bitlen=0, cnt=0, go to IDLE.
//  - Widths: cnt is $clog2(NL)+1 bits. bitlen is 8*LENB bits and wraps modulo 2^(8*LENB).
//  - Latency: from the last byte accepted to the first blk_valid is 2 cycles (PAD, ISSUE),
//    or 1 cycle for a full block. Core compute time adds only WAIT cycles.
// TESTING
//  1. "abc" (61 62 63, last on 63) -> one block: 61 62 63 80, zeros, bytes 56..63 =
//     00..00 18; blk_first=blk_last=1; msg_done 1 cycle after core_done.
//  2. 55 bytes of 0xAA -> one block: 0x80 at byte 55, tail = 0x1B8; exactly one
//     blk_valid handshake.
//  3. 56 bytes -> block 1: 0x80 at byte 56, bytes 57..63=0, blk_last=0, blk_first=1;
//     block 2: all zero, tail 0x1C0, blk_first=0, blk_last=1.
//  4. 64 bytes -> block 1 = data, blk_last=0; block 2 = 80 00.., tail 0x200.
//     130 bytes -> 3 blocks, tail 0x410.
//  5. Hold blk_ready=0 for 10 cycles in ISSUE -> blk_valid, blk_data, blk_first and
//     blk_last stable; in_ready=0; no msg_done.
//  6. Assert rst=0 mid-WAIT; separately pulse clr in FILL -> all outputs 0 / IDLE.
//     A new "abc" afterwards gives the case-1 result with blk_first=1.

Source files
------------

// File: rtl/sha_msg_ctrl.sv
// SHA message sequencer: packs bytes into NL-byte blocks,
// appends FIPS-180 padding and length, hands blocks to the core.
module sha_msg_ctrl #(
  parameter int NL   = 64,
  parameter int LENB = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic            in_last,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic [8*NL-1:0] blk_data,
  output logic            blk_first,
  output logic            blk_last,
  input  logic            core_done,
  output logic            msg_done,
  output logic            busy
);

  localparam int CW = $clog2(NL) + 1;
  localparam int BW = 8 * LENB;
  localparam logic [8*NL-1:0] LEAD =
    {8'h80, {(8*NL-8){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, FILL, PAD, ISSUE, WAIT, DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bitlen;
  logic            first;
  logic            pad_pend;
  logic            len_pend;
  logic [8*NL-1:0] buffer;

  logic            take;
  logic [CW-1:0]   cnt_inc;
  logic            fits;
  logic [8*NL-1:0] wr_buf;
  logic [8*NL-1:0] pad_buf;
  logic [8*NL-1:0] len_buf;

  assign blk_data = buffer;
  assign take     = in_valid & in_ready;
  assign cnt_inc  = cnt + 1'b1;
  assign fits     = cnt_inc <= CW'(NL - LENB);

  always_comb begin
    wr_buf = buffer;
    wr_buf[8*(NL-1-int'(cnt)) +: 8] = in_data;
  end

  // 0x80 terminator, zero the rest, length in tail if it fits
  always_comb begin
    pad_buf = buffer;
    for (int k = 0; k < NL; k++) begin
      if (k == int'(cnt))
        pad_buf[8*(NL-1-k) +: 8] = 8'h80;
      else if (k > int'(cnt))
        pad_buf[8*(NL-1-k) +: 8] = 8'h00;
    end
    if (fits)
      pad_buf[BW-1:0] = bitlen;
  end

  always_comb begin
    len_buf = '0;
    len_buf[BW-1:0] = bitlen;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitlen    <= '0;
      first     <= 1'b1;
      pad_pend  <= 1'b0;
      len_pend  <= 1'b0;
      buffer    <= '0;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
      msg_done  <= 1'b0;
      busy      <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      bitlen    <= '0;
      first     <= 1'b1;
      pad_pend  <= 1'b0;
      len_pend  <= 1'b0;
      buffer    <= '0;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
      msg_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (take) begin
            buffer <= wr_buf;
            cnt    <= CW'(1);
            bitlen <= BW'(8);
            first  <= 1'b1;
            busy   <= 1'b1;
            if (in_last) begin
              state    <= PAD;
              in_ready <= 1'b0;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (take) begin
            buffer <= wr_buf;
            cnt    <= cnt_inc;
            bitlen <= bitlen + BW'(8);
            if (cnt_inc == CW'(NL)) begin
              state     <= ISSUE;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
              blk_first <= first;
              blk_last  <= 1'b0;
              pad_pend  <= in_last;
            end else if (in_last) begin
              state    <= PAD;
              in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          buffer    <= pad_buf;
          blk_last  <= fits;
          len_pend  <= ~fits;
          blk_first <= first;
          blk_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            first     <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            if (blk_last) begin
              state    <= DONE;
              msg_done <= 1'b1;
            end else if (pad_pend || len_pend) begin
              buffer    <= pad_pend ?
                           (len_buf | LEAD) : len_buf;
              pad_pend  <= 1'b0;
              len_pend  <= 1'b0;
              blk_last  <= 1'b1;
              blk_first <= first;
              blk_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              cnt      <= '0;
              in_ready <= 1'b1;
              state    <= FILL;
            end
          end
        end
        DONE: begin
          bitlen    <= '0;
          cnt       <= '0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          blk_first <= 1'b0;
          blk_last  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_ctrl.sv
// Scoreboard bench for sha_msg_ctrl: directed messages,
// expected blocks queued at stimulus time, checked on handshake.
module tb_sha_msg_ctrl;

  localparam int NL = 64;

  typedef struct {
    logic [8*NL-1:0] data;
    logic            first;
    logic            last;
  } exp_t;

  localparam logic [511:0] ABC =
    {32'h61626380, 416'h0, 64'h18};

  logic            clk = 0;
  logic            rst = 0;
  logic            clr = 0;
  logic            in_valid = 0;
  logic            in_ready;
  logic [7:0]      in_data = 0;
  logic            in_last = 0;
  logic            blk_valid;
  logic            blk_ready = 1;
  logic [8*NL-1:0] blk_data;
  logic            blk_first;
  logic            blk_last;
  logic            core_done = 0;
  logic            msg_done;
  logic            busy;

  exp_t       exp_q[$];
  logic [7:0] msg[$];
  int total = 0;
  int bad = 0;
  int msg_cnt = 0;
  int blk_cnt = 0;

  sha_msg_ctrl #(.NL(NL), .LENB(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first),
    .blk_last(blk_last), .core_done(core_done),
    .msg_done(msg_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // core model: done pulse a few cycles after each block
  initial forever begin
    @(posedge clk);
    if (rst && blk_valid && blk_ready) begin
      repeat (3) @(posedge clk);
      #1 core_done = 1;
      @(posedge clk);
      #1 core_done = 0;
    end
  end

  // monitor
  initial begin
    exp_t e;
    logic prev_cd;
    logic prev_md;
    prev_cd = 0;
    prev_md = 0;
    forever begin
      @(negedge clk);
      if (rst && blk_valid && blk_ready) begin
        blk_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL blk unexpected act=%h", blk_data);
        end else begin
          e = exp_q.pop_front();
          if (blk_data !== e.data || blk_first !== e.first ||
              blk_last !== e.last) begin
            bad++;
            $display("FAIL blk%0d act=%h f%b l%b exp=%h f%b l%b",
              blk_cnt, blk_data, blk_first, blk_last,
              e.data, e.first, e.last);
          end
        end
      end
      if (rst && msg_done) begin
        msg_cnt++;
        total++;
        if (!prev_cd || prev_md) begin
          bad++;
          $display("FAIL msg_done timing act cd=%b md=%b req 1/0",
            prev_cd, prev_md);
        end
      end
      prev_cd = core_done;
      prev_md = msg_done;
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  task automatic push_model();
    logic [7:0] p[$];
    logic [63:0] bits;
    int nb;
    exp_t e;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 64; k++)
        e.data[8*(63-k) +: 8] = p[64*b+k];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_abc();
    exp_t e;
    e.data = ABC;
    e.first = 1;
    e.last = 1;
    exp_q.push_back(e);
  endtask

  task automatic set_abc();
    msg = {8'h61, 8'h62, 8'h63};
  endtask

  task automatic drive_msg(input bit with_last);
    int n;
    bit acc;
    for (int i = 0; i < msg.size(); i++) begin
      in_valid = 1;
      in_data = msg[i];
      in_last = with_last && (i == msg.size() - 1);
      n = 0;
      do begin
        @(posedge clk);
        acc = in_ready;
        n++;
      end while (!acc && n < 2000);
      #1;
      if (!acc) begin
        check("in_ready timeout", 0, 1);
        break;
      end
    end
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic wait_msgs(input int target);
    int n = 0;
    while (msg_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("msg_done count", 64'(msg_cnt), 64'(target));
  endtask

  task automatic check_zero(input string nm);
    check(nm, {58'h0, in_ready, blk_valid, blk_first,
               blk_last, msg_done, busy}, 0);
    check({nm, " data"}, 64'(blk_data != 0), 0);
  endtask

  initial begin
    int b0;
    int n;
    logic [511:0] cap;
    logic cf, cl;
    bit stable;

    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 1;
    @(posedge clk);
    #1 check("idle in_ready", 64'(in_ready), 1);
    check("idle busy", 64'(busy), 0);

    // 1: "abc" with latency check
    set_abc();
    push_abc();
    drive_msg(1);
    check("pad cycle valid", 64'(blk_valid), 0);
    check("pad cycle busy", 64'(busy), 1);
    @(posedge clk);
    #1 check("issue valid", 64'(blk_valid), 1);
    wait_msgs(1);

    // 2: 55 bytes of 0xAA
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'hAA);
    b0 = blk_cnt;
    push_model();
    drive_msg(1);
    wait_msgs(2);
    check("55B blocks", 64'(blk_cnt - b0), 1);

    // 3: 56 bytes -> extra length block
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'(i));
    b0 = blk_cnt;
    push_model();
    drive_msg(1);
    wait_msgs(3);
    check("56B blocks", 64'(blk_cnt - b0), 2);

    // 4: 64 and 130 bytes
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i * 3));
    b0 = blk_cnt;
    push_model();
    drive_msg(1);
    wait_msgs(4);
    check("64B blocks", 64'(blk_cnt - b0), 2);
    msg.delete();
    for (int i = 0; i < 130; i++) msg.push_back(8'(255 - i));
    b0 = blk_cnt;
    push_model();
    drive_msg(1);
    wait_msgs(5);
    check("130B blocks", 64'(blk_cnt - b0), 3);

    // 5: core stalls blk_ready
    blk_ready = 0;
    set_abc();
    push_abc();
    drive_msg(1);
    @(posedge clk);
    #1 check("stall valid", 64'(blk_valid), 1);
    cap = blk_data;
    cf = blk_first;
    cl = blk_last;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (blk_valid !== 1 || blk_data !== cap ||
          blk_first !== cf || blk_last !== cl ||
          in_ready !== 0 || msg_done !== 0)
        stable = 0;
    end
    check("stall stable", 64'(stable), 1);
    @(posedge clk);
    #1 blk_ready = 1;
    wait_msgs(6);

    // 6a: async reset while waiting on the core
    set_abc();
    push_abc();
    b0 = blk_cnt;
    drive_msg(1);
    n = 0;
    while (blk_cnt == b0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 check("6a handshake", 64'(blk_cnt - b0), 1);
    rst = 0;
    #1 check_zero("async rst");
    @(posedge clk);
    #1 rst = 1;
    repeat (8) @(posedge clk);
    #1 check("no msg_done after rst", 64'(msg_cnt), 6);
    check("idle after rst", 64'(busy), 0);

    // 6b: clr mid-FILL, then fresh "abc"
    msg = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_msg(0);
    check("fill busy", 64'(busy), 1);
    clr = 1;
    @(posedge clk);
    #1 check_zero("clr");
    clr = 0;
    @(posedge clk);
    #1;
    set_abc();
    push_abc();
    drive_msg(1);
    wait_msgs(7);

    repeat (5) @(posedge clk);
    #1 check("queue empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
